// File: rtl/pipe_event_monitor.sv
// pipe_event_monitor: hazard performance counters plus a time-stamped,
// show-ahead trace FIFO of hazard events. Counters saturate; the FIFO drops
// (and counts) pushes that arrive while it is full with no pop in the same cycle.
module pipe_event_monitor #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    input  logic [1:0]                    forwardA,
    input  logic [1:0]                    forwardB,
    input  logic                          flush_IFID,
    input  logic                          flush_IDEX,
    input  logic [31:0]                   pc_if,
    input  logic [2:0]                    cnt_sel,
    output logic [CNT_W-1:0]              cnt_data,
    input  logic                          trace_rd,
    output logic                          trace_valid,
    output logic [63:0]                   trace_data,
    output logic [$clog2(FIFO_DEPTH):0]   trace_count,
    output logic                          overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NCNT = 6;

    logic [7:0]        flags;
    logic              fwd_any, flush_any;
    logic              push_req, pop, full, do_push, drop;
    logic [23:0]       ts;
    logic [63:0]       entry;
    logic [NCNT-1:0]   inc;
    logic [CNT_W-1:0]  cnt [NCNT];
    logic [CNT_W-1:0]  sel_val;
    logic [63:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    assign fwd_any   = |forwardA | |forwardB;
    assign flush_any = flush_IFID | flush_IDEX;
    assign flags     = {2'b00, flush_IDEX, flush_IFID, |forwardB, |forwardA, branch_taken, stall};

    // clr wins over everything in its cycle, so gate the push request with it
    assign push_req = en & ~clr & (|flags);
    assign pop      = trace_rd & trace_valid & ~clr;
    assign full     = (trace_count == (AW+1)'(FIFO_DEPTH));
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // counter 0 doubles as the timestamp source; narrow counters are zero-extended
    generate
        if (CNT_W >= 24) begin : g_ts_wide
            assign ts = cnt[0][23:0];
        end else begin : g_ts_narrow
            assign ts = {{(24-CNT_W){1'b0}}, cnt[0]};
        end
    endgenerate

    assign entry = {ts, flags, branch_taken ? branch_target : pc_if};
    assign inc   = {drop, flush_any, fwd_any, branch_taken, stall, 1'b1} & {NCNT{en & ~clr}};

    // saturating event counters
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCNT; i++) begin
            if (!rstn || clr)
                cnt[i] <= '0;
            else if (inc[i] && !(&cnt[i]))
                cnt[i] <= cnt[i] + 1'b1;
        end
    end

    // select mux; codes 6 and 7 fall through to zero
    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NCNT; i++)
            if (cnt_sel == 3'(i)) sel_val = cnt[i];
    end

    // cnt_data is registered from the pre-update counter values
    always_ff @(posedge clk) begin
        if (!rstn) cnt_data <= '0;
        else       cnt_data <= sel_val;
    end

    // trace storage; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= entry;
    end

    // pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            trace_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   trace_count <= trace_count + 1'b1;
                2'b01:   trace_count <= trace_count - 1'b1;
                default: trace_count <= trace_count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // show-ahead head; forced to zero when empty so reset reads clean
    assign trace_valid = (trace_count != '0);
    assign trace_data  = trace_valid ? mem[rd_ptr] : 64'd0;

endmodule

// File: tb/tb_pipe_event_monitor.sv
// Directed bench for pipe_event_monitor. A second instance with CNT_W=4 shares
// all inputs and is used only for the counter saturation check.
module tb_pipe_event_monitor;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rstn, en, clr, stall, branch_taken, flush_IFID, flush_IDEX, trace_rd;
    logic [31:0] branch_target, pc_if;
    logic [1:0]  forwardA, forwardB;
    logic [2:0]  cnt_sel;

    logic [31:0] cnt_data;
    logic        trace_valid, overflow;
    logic [63:0] trace_data;
    logic [4:0]  trace_count;

    logic [3:0]  s_cnt_data;
    logic        s_trace_valid, s_overflow;
    logic [63:0] s_trace_data;
    logic [4:0]  s_trace_count;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q[$];

    always #5 clk = ~clk;

    pipe_event_monitor #(.FIFO_DEPTH(D), .CNT_W(32)) u_dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .forwardA(forwardA), .forwardB(forwardB),
        .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .pc_if(pc_if),
        .cnt_sel(cnt_sel), .cnt_data(cnt_data), .trace_rd(trace_rd),
        .trace_valid(trace_valid), .trace_data(trace_data),
        .trace_count(trace_count), .overflow(overflow));

    pipe_event_monitor #(.FIFO_DEPTH(D), .CNT_W(4)) u_sat (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .forwardA(forwardA), .forwardB(forwardB),
        .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .pc_if(pc_if),
        .cnt_sel(cnt_sel), .cnt_data(s_cnt_data), .trace_rd(trace_rd),
        .trace_valid(s_trace_valid), .trace_data(s_trace_data),
        .trace_count(s_trace_count), .overflow(s_overflow));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic quiet();
        stall = 0; branch_taken = 0; forwardA = 0; forwardB = 0;
        flush_IFID = 0; flush_IDEX = 0; trace_rd = 0; clr = 0;
    endtask

    initial begin
        rstn = 0; en = 1; clr = 0; cnt_sel = 0; trace_rd = 0;
        branch_target = 32'h0000_0040; pc_if = 32'h0000_0010;
        stall = 1; branch_taken = 1; forwardA = 2'b01; forwardB = 2'b10;
        flush_IFID = 1; flush_IDEX = 1;

        // reset with events asserted
        repeat (2) tick();
        chk("rst_cnt_data", 64'(cnt_data), 64'd0);
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_data", trace_data, 64'd0);
        chk("rst_count", 64'(trace_count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // 10 idle enabled cycles
        rstn = 1; quiet();
        repeat (10) tick();
        chk("idle_cnt_lag", 64'(cnt_data), 64'd9);
        en = 0; tick();
        chk("idle_cnt0", 64'(cnt_data), 64'd10);
        chk("idle_valid", 64'(trace_valid), 64'd0);

        // single branch at timestamp 5
        clr = 1; tick(); clr = 0; en = 1;
        repeat (5) tick();
        branch_taken = 1; branch_target = 32'h0000_0040; pc_if = 32'h0000_0010;
        tick();
        quiet();
        chk("br_valid", 64'(trace_valid), 64'd1);
        chk("br_data", trace_data, {24'd5, 8'h02, 32'h0000_0040});
        cnt_sel = 2; tick();
        chk("br_cnt2", 64'(cnt_data), 64'd1);

        // combined event at timestamp 7
        stall = 1; forwardA = 2'b10; flush_IDEX = 1; pc_if = 32'h0000_1234;
        tick();
        quiet();
        chk("comb_count", 64'(trace_count), 64'd2);
        trace_rd = 1; tick(); trace_rd = 0;
        chk("comb_count_pop", 64'(trace_count), 64'd1);
        chk("comb_data", trace_data, {24'd7, 8'h25, 32'h0000_1234});
        cnt_sel = 1; tick(); chk("comb_cnt1", 64'(cnt_data), 64'd1);
        cnt_sel = 3; tick(); chk("comb_cnt3", 64'(cnt_data), 64'd1);
        cnt_sel = 4; tick(); chk("comb_cnt4", 64'(cnt_data), 64'd1);

        // overflow: 20 stalls into a 16-deep FIFO
        clr = 1; tick(); clr = 0;
        chk("clr_count", 64'(trace_count), 64'd0);
        chk("clr_valid", 64'(trace_valid), 64'd0);
        stall = 1; pc_if = 32'h0000_0100;
        repeat (20) tick();
        chk("ovf_count", 64'(trace_count), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", trace_data, {24'd0, 8'h01, 32'h0000_0100});
        trace_rd = 1; tick();
        quiet();
        chk("ovf_pushpop_count", 64'(trace_count), 64'd16);
        chk("ovf_pushpop_head", trace_data, {24'd1, 8'h01, 32'h0000_0100});
        cnt_sel = 5; tick();
        chk("ovf_cnt5", 64'(cnt_data), 64'd4);
        cnt_sel = 1; tick();
        chk("stall_cnt_wide", 64'(cnt_data), 64'd21);
        chk("stall_cnt_sat", 64'(s_cnt_data), 64'd15);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // clr together with an event
        clr = 1; stall = 1; branch_taken = 1; tick();
        quiet();
        chk("clrev_count", 64'(trace_count), 64'd0);
        chk("clrev_valid", 64'(trace_valid), 64'd0);
        chk("clrev_ovf", 64'(overflow), 64'd0);
        cnt_sel = 1; tick(); chk("clrev_cnt1", 64'(cnt_data), 64'd0);
        cnt_sel = 2; tick(); chk("clrev_cnt2", 64'(cnt_data), 64'd0);
        cnt_sel = 5; tick(); chk("clrev_cnt5", 64'(cnt_data), 64'd0);

        // 40 pushes with interleaved pops across pointer wrap
        clr = 1; tick(); clr = 0;
        q.delete();
        for (int j = 0; j < 40; j++) begin
            stall = 1; pc_if = 32'(j);
            trace_rd = (j % 4 != 0);
            if (trace_rd) begin
                chk("wrap_valid", 64'(trace_valid), 64'd1);
                chk("wrap_data", trace_data, q[0]);
            end
            tick();
            if (trace_rd) void'(q.pop_front());
            q.push_back({24'(j), 8'h01, 32'(j)});
        end
        quiet();
        chk("wrap_count", 64'(trace_count), 64'(q.size()));
        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0) break;
            trace_rd = 1;
            chk("drain_data", trace_data, q[0]);
            tick();
            void'(q.pop_front());
        end
        trace_rd = 0;
        chk("drain_count", 64'(trace_count), 64'd0);
        chk("drain_valid", 64'(trace_valid), 64'd0);

        // en=0: events frozen, pops still drain
        clr = 1; tick(); clr = 0;
        stall = 1; pc_if = 32'h0000_0200;
        repeat (3) tick();
        en = 0; forwardB = 2'b01;
        for (int k = 0; k < 5; k++) begin
            trace_rd = (k < 3);
            if (trace_rd) chk("en0_data", trace_data, {24'(k), 8'h01, 32'h0000_0200});
            tick();
        end
        quiet();
        chk("en0_count", 64'(trace_count), 64'd0);
        chk("en0_valid", 64'(trace_valid), 64'd0);
        cnt_sel = 1; tick(); chk("en0_cnt1", 64'(cnt_data), 64'd3);
        cnt_sel = 3; tick(); chk("en0_cnt3", 64'(cnt_data), 64'd0);
        cnt_sel = 0; tick(); chk("en0_cnt0", 64'(cnt_data), 64'd3);
        cnt_sel = 6; tick(); chk("sel6_zero", 64'(cnt_data), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
